// File: rtl/pwm_tick_gen.sv
// Tick-driven PWM generator with a double-buffered period/duty configuration.
// New settings are taken over a valid/ready handshake and only take effect on a period boundary.
module pwm_tick_gen #(
    parameter int WIDTH      = 16,
    parameter int PERIOD_RST = 20000,
    parameter int DUTY_RST   = 1500
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output logic             pwm_o,
    output logic             cycle_start_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [WIDTH-1:0] PERIOD_INIT = WIDTH'(PERIOD_RST);
    localparam logic [WIDTH-1:0] DUTY_INIT   = WIDTH'(DUTY_RST);
    localparam logic [WIDTH-1:0] PERIOD_MIN  = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] period_shd;
    logic [WIDTH-1:0] duty_shd;
    logic             pending;

    logic             accept;
    logic             boundary;
    logic             apply;
    logic [WIDTH-1:0] period_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic [WIDTH-1:0] count_inc;

    assign busy_o    = (state != IDLE);
    assign accept    = cfg_valid_i && cfg_ready_o;
    assign count_inc = count + ONE;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
        apply      = 1'b0;
        boundary   = tick_i && (count == period_act - ONE);
        period_nxt = period_act;
        duty_nxt   = duty_act;
        if (state == IDLE) begin
            apply = pending;
        end else if (boundary) begin
            apply = pending;
        end
        if (apply) begin
            period_nxt = (period_shd < PERIOD_MIN) ? PERIOD_MIN : period_shd;
            duty_nxt   = duty_shd;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            count         <= '0;
            pwm_o         <= 1'b0;
            cycle_start_o <= 1'b0;
            cfg_ready_o   <= 1'b1;
            period_act    <= PERIOD_INIT;
            duty_act      <= DUTY_INIT;
            period_shd    <= '0;
            duty_shd      <= '0;
            pending       <= 1'b0;
        end else begin
            cycle_start_o <= 1'b0;

            if (apply) begin
                period_act <= period_nxt;
                duty_act   <= duty_nxt;
                pending    <= 1'b0;
            end
            if (accept) begin
                period_shd <= period_i;
                duty_shd   <= duty_i;
                pending    <= 1'b1;
            end
            // Ready stays low through the apply edge and rises on the following one.
            if (accept || apply) begin
                cfg_ready_o <= 1'b0;
            end else begin
                cfg_ready_o <= !pending;
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state         <= RUN;
                        count         <= '0;
                        pwm_o         <= (duty_nxt != '0);
                        cycle_start_o <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    // enable_i picks the mode for this edge, so a boundary with enable low ends the run.
                    state <= enable_i ? RUN : DRAIN;
                    if (tick_i) begin
                        if (boundary) begin
                            count <= '0;
                            if (enable_i) begin
                                pwm_o         <= (duty_nxt != '0);
                                cycle_start_o <= 1'b1;
                            end else begin
                                state <= IDLE;
                                pwm_o <= 1'b0;
                            end
                        end else begin
                            count <= count_inc;
                            pwm_o <= (count_inc < duty_act);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
